// File: rtl/vm_pkg.sv
// Shared definitions for the change dispenser: coin values, one-hot eject
// bit positions, the cents word width, the controller state enumeration and
// small helpers for coin values and nickel rounding.
package vm_pkg;

  localparam int CENTS_W = 14;
  localparam int COIN_N  = 4;

  typedef logic [CENTS_W-1:0]     cents_t;
  typedef logic [COIN_N-1:0][7:0] inv_t;    // per-coin counts, indexed by eject bit

  // Bit positions inside the one-hot {dollar, quarter, dime, nickel} word.
  localparam int EJ_DOLLAR  = 3;
  localparam int EJ_QUARTER = 2;
  localparam int EJ_DIME    = 1;
  localparam int EJ_NICKEL  = 0;

  localparam cents_t VAL_DOLLAR  = 14'd100;
  localparam cents_t VAL_QUARTER = 14'd25;
  localparam cents_t VAL_DIME    = 14'd10;
  localparam cents_t VAL_NICKEL  = 14'd5;

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, DONE, FAULT} state_t;

  function automatic cents_t coinValue(input logic [COIN_N-1:0] oneHot);
    cents_t val;
    val = '0;
    if (oneHot[EJ_DOLLAR])       val = VAL_DOLLAR;
    else if (oneHot[EJ_QUARTER]) val = VAL_QUARTER;
    else if (oneHot[EJ_DIME])    val = VAL_DIME;
    else if (oneHot[EJ_NICKEL])  val = VAL_NICKEL;
    return val;
  endfunction

  // Cents below the nickel can never be paid; they are dropped up front.
  function automatic cents_t floorToNickel(input cents_t cents);
    return cents - (cents % VAL_NICKEL);
  endfunction

  function automatic logic hasOddCents(input cents_t cents);
    return (cents % VAL_NICKEL) != '0;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Host/hopper signal bundle of the change dispenser.
//   master : the host side (drives start, change_cents, inventory load, eject_ack)
//   slave  : the dispenser side (drives eject, busy, done, short, fault,
//            remaining, inv_empty)
interface change_dispenser_if
  import vm_pkg::*;
;
  logic         start;
  cents_t       change_cents;
  logic         inv_load;
  logic [7:0]   inv_dollar;
  logic [7:0]   inv_quarter;
  logic [7:0]   inv_dime;
  logic [7:0]   inv_nickel;
  logic [3:0]   eject;
  logic         eject_ack;
  logic         busy;
  logic         done;
  logic         short;
  logic         fault;
  cents_t       remaining;
  logic [3:0]   inv_empty;

  modport master (
    output start, change_cents, inv_load,
    output inv_dollar, inv_quarter, inv_dime, inv_nickel, eject_ack,
    input  eject, busy, done, short, fault, remaining, inv_empty
  );

  modport slave (
    input  start, change_cents, inv_load,
    input  inv_dollar, inv_quarter, inv_dime, inv_nickel, eject_ack,
    output eject, busy, done, short, fault, remaining, inv_empty
  );
endinterface

// File: rtl/coin_select.sv
// Combinational priority picker: chooses the largest coin whose value fits in
// the amount still owed and whose inventory is nonzero.
//   remaining : cents still owed
//   inv       : per-coin inventory counts (eject bit order)
//   choice    : one-hot coin to eject (zero when nothing qualifies)
//   none      : no coin qualifies (also true when remaining is zero)
module coin_select
  import vm_pkg::*;
(
  input  cents_t              remaining,
  input  inv_t                inv,
  output logic [COIN_N-1:0]   choice,
  output logic                none
);

  // NOTE: every output of an always_comb gets a default before any branch so
  // that no path leaves it unassigned and a latch gets inferred.
  always_comb begin
    choice = '0;
    if (remaining >= VAL_DOLLAR && inv[EJ_DOLLAR] != '0)
      choice[EJ_DOLLAR] = 1'b1;
    else if (remaining >= VAL_QUARTER && inv[EJ_QUARTER] != '0)
      choice[EJ_QUARTER] = 1'b1;
    else if (remaining >= VAL_DIME && inv[EJ_DIME] != '0)
      choice[EJ_DIME] = 1'b1;
    else if (remaining >= VAL_NICKEL && inv[EJ_NICKEL] != '0)
      choice[EJ_NICKEL] = 1'b1;
  end

  assign none = (choice == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin change dispenser controller. Loads a coin inventory, then pays out a
// requested amount greedily one coin at a time through a hopper handshake
// (eject held until eject_ack), flagging short payouts and hopper timeouts.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : change_dispenser_if.slave (request, inventory, hopper, status)
//   ACK_TIMEOUT: cycles allowed in EJECT without eject_ack before FAULT
module change_dispenser
  import vm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  change_dispenser_if.slave  bus
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t              state, stateNext;
  inv_t                inv;
  cents_t              remainingQ;
  logic                shortQ;
  logic [COIN_N-1:0]   ejectQ;
  logic [CNT_W-1:0]    ackCnt;
  logic [COIN_N-1:0]   choice;
  logic                none;
  logic                ackTimeout;

  coin_select uSelect (
    .remaining (remainingQ),
    .inv       (inv),
    .choice    (choice),
    .none      (none)
  );

  // Last permitted EJECT cycle: no acknowledge here means the hopper is stuck.
  assign ackTimeout = (ackCnt == CNT_W'(ACK_TIMEOUT - 1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start && !bus.inv_load) stateNext = SELECT;
      SELECT:  stateNext = none ? DONE : EJECT;
      EJECT:   if (bus.eject_ack)   stateNext = SELECT;
               else if (ackTimeout) stateNext = FAULT;
      DONE:    stateNext = IDLE;
      FAULT:   stateNext = FAULT;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: the inventory is a small register bank, not a RAM, so it takes the
  // asynchronous reset like the rest of the datapath (empty after reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv        <= '0;
      remainingQ <= '0;
      shortQ     <= 1'b0;
      ejectQ     <= '0;
      ackCnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inv_load) begin
            inv[EJ_DOLLAR]  <= bus.inv_dollar;
            inv[EJ_QUARTER] <= bus.inv_quarter;
            inv[EJ_DIME]    <= bus.inv_dime;
            inv[EJ_NICKEL]  <= bus.inv_nickel;
          end else if (bus.start) begin
            remainingQ <= floorToNickel(bus.change_cents);
            shortQ     <= hasOddCents(bus.change_cents);
          end
        end
        SELECT: begin
          ackCnt <= '0;
          if (!none)                 ejectQ <= choice;
          else if (remainingQ != '0) shortQ <= 1'b1;
        end
        EJECT: begin
          if (bus.eject_ack) begin
            for (int i = 0; i < COIN_N; i++)
              if (ejectQ[i]) inv[i] <= inv[i] - 8'd1;
            remainingQ <= remainingQ - coinValue(ejectQ);
            ejectQ     <= '0;
          end else if (ackTimeout) begin
            ejectQ <= '0;
          end else begin
            ackCnt <= ackCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.eject     = ejectQ;
  assign bus.busy      = (state == SELECT) || (state == EJECT);
  assign bus.done      = (state == DONE);
  assign bus.short     = shortQ;
  assign bus.fault     = (state == FAULT);
  assign bus.remaining = remainingQ;

  assign bus.inv_empty[EJ_DOLLAR]  = (inv[EJ_DOLLAR]  == '0);
  assign bus.inv_empty[EJ_QUARTER] = (inv[EJ_QUARTER] == '0);
  assign bus.inv_empty[EJ_DIME]    = (inv[EJ_DIME]    == '0);
  assign bus.inv_empty[EJ_NICKEL]  = (inv[EJ_NICKEL]  == '0);

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed vector table, hand
// sequences for latency/timeout/reset corners, and randomized payouts scored
// against a greedy-payout reference model.
module tb_change_dispenser;
  import vm_pkg::*;

  localparam int ACK_TIMEOUT   = 16;
  localparam int PAYOUT_BUDGET = 3000;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  change_dispenser_if bus ();

  change_dispenser #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed results of the last payout, and model expectations.
  int   obsSeq[$];
  bit   gotDone;
  logic obsShort;
  int   obsRem;
  int   expSeq[$];
  bit   expShort;
  int   expRem;
  int   modelInv[4];
  int   coinVal[4] = '{5, 10, 25, 100};

  typedef struct {
    logic             load;
    logic [3:0][7:0]  invVals;   // [3]=dollar .. [0]=nickel
    logic [13:0]      cents;
    logic [3:0][7:0]  expCnt;    // coins expected per type
    logic             expShort;
    logic [13:0]      expRem;
    logic [3:0]       expEmpty;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int coinIdx(input logic [3:0] oneHot);
    int idx = -1;
    for (int i = 0; i < 4; i++) if (oneHot[i]) idx = i;
    return idx;
  endfunction

  task automatic loadInv(input logic [3:0][7:0] vals);
    bus.inv_dollar  = vals[3];
    bus.inv_quarter = vals[2];
    bus.inv_dime    = vals[1];
    bus.inv_nickel  = vals[0];
    for (int i = 0; i < 4; i++) modelInv[i] = int'(vals[i]);
    bus.inv_load = 1'b1;
    tick();
    bus.inv_load = 1'b0;
  endtask

  // Greedy change-making from the rules: largest coin that fits and is stocked.
  task automatic modelPayout(input int cents);
    int  rem;
    int  pick;
    bit  stop;
    expSeq.delete();
    rem      = (cents / 5) * 5;
    expShort = (cents % 5) != 0;
    stop     = 0;
    while (rem != 0 && !stop) begin
      pick = -1;
      for (int i = 3; i >= 0; i--)
        if (pick < 0 && coinVal[i] <= rem && modelInv[i] > 0) pick = i;
      if (pick < 0) begin
        expShort = 1;
        stop     = 1;
      end else begin
        expSeq.push_back(pick);
        modelInv[pick]--;
        rem -= coinVal[pick];
      end
    end
    expRem = rem;
  endtask

  function automatic logic [3:0] modelEmpty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (modelInv[i] == 0);
    return e;
  endfunction

  // Issue a start, act as the hopper (ack after a random delay), collect ejects.
  task automatic doPayout(input logic [13:0] cents, input int dLo, input int dHi);
    int         cyc;
    int         delay;
    logic [3:0] coin;
    bit         holdOk;
    obsSeq.delete();
    gotDone  = 0;
    obsShort = 1'b0;
    obsRem   = 0;
    bus.change_cents = cents;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (!gotDone && cyc < PAYOUT_BUDGET) begin
      if (bus.done) begin
        gotDone  = 1;
        obsShort = bus.short;
        obsRem   = int'(bus.remaining);
      end else if (bus.eject != 4'b0000) begin
        coin   = bus.eject;
        delay  = int'($urandom_range(dHi, dLo));
        holdOk = 1;
        for (int d = 0; d < delay; d++) begin
          tick();
          cyc++;
          if (bus.eject !== coin) holdOk = 0;
        end
        check("eject_onehot", 32'($onehot(coin)), 32'd1);
        check("eject_hold", 32'(holdOk), 32'd1);
        obsSeq.push_back(coinIdx(coin));
        bus.eject_ack = 1'b1;
        tick();
        bus.eject_ack = 1'b0;
        cyc++;
      end else begin
        tick();
        cyc++;
      end
    end
    check("payout_done", 32'(gotDone), 32'd1);
    if (gotDone) begin
      tick();
      check("done_pulse", 32'(bus.done), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_eject"},     32'(bus.eject),     32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
    check({tag, "_short"},     32'(bus.short),     32'd0);
    check({tag, "_fault"},     32'(bus.fault),     32'd0);
    check({tag, "_remaining"}, 32'(bus.remaining), 32'd0);
    check({tag, "_inv_empty"}, 32'(bus.inv_empty), 32'hF);
  endtask

  initial begin
    int         cnt[4];
    int         cents;
    int         n;
    bit         seen;
    logic [3:0][7:0] rv;

    checks   = 0;
    failures = 0;
    bus.start = 1'b0; bus.change_cents = '0; bus.inv_load = 1'b0;
    bus.inv_dollar = '0; bus.inv_quarter = '0; bus.inv_dime = '0; bus.inv_nickel = '0;
    bus.eject_ack = 1'b0;
    for (int i = 0; i < 4; i++) modelInv[i] = 0;

    vecs[0] = '{1'b1, {8'd10, 8'd10, 8'd10, 8'd10}, 14'd140,  {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 14'd0,    4'b0000};
    vecs[1] = '{1'b0, {8'd0,  8'd0,  8'd0,  8'd0},  14'd1260, {8'd9, 8'd9, 8'd9, 8'd9}, 1'b0, 14'd0,    4'b1111};
    vecs[2] = '{1'b1, {8'd0,  8'd0,  8'd10, 8'd0},  14'd50,   {8'd0, 8'd0, 8'd5, 8'd0}, 1'b0, 14'd0,    4'b1101};
    vecs[3] = '{1'b1, {8'd0,  8'd0,  8'd0,  8'd1},  14'd15,   {8'd0, 8'd0, 8'd0, 8'd1}, 1'b1, 14'd10,   4'b1111};
    vecs[4] = '{1'b1, {8'd5,  8'd5,  8'd5,  8'd5},  14'd0,    {8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 14'd0,    4'b0000};
    vecs[5] = '{1'b0, {8'd0,  8'd0,  8'd0,  8'd0},  14'd37,   {8'd0, 8'd1, 8'd1, 8'd0}, 1'b1, 14'd0,    4'b0000};
    vecs[6] = '{1'b0, {8'd0,  8'd0,  8'd0,  8'd0},  14'd9995, {8'd5, 8'd4, 8'd4, 8'd5}, 1'b1, 14'd9330, 4'b1111};
    vecs[7] = '{1'b1, {8'd1,  8'd0,  8'd3,  8'd0},  14'd30,   {8'd0, 8'd0, 8'd3, 8'd0}, 1'b0, 14'd0,    4'b0111};

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    // Directed vector table.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].load) loadInv(vecs[v].invVals);
      doPayout(vecs[v].cents, 0, 3);
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      foreach (obsSeq[i]) if (obsSeq[i] >= 0) cnt[obsSeq[i]]++;
      for (int c = 0; c < 4; c++)
        check($sformatf("vec%0d_count_coin%0d", v, c), 32'(cnt[c]), 32'(vecs[v].expCnt[c]));
      for (int i = 1; i < obsSeq.size(); i++)
        check($sformatf("vec%0d_order", v), 32'(obsSeq[i] <= obsSeq[i-1]), 32'd1);
      check($sformatf("vec%0d_short", v),     32'(obsShort),      32'(vecs[v].expShort));
      check($sformatf("vec%0d_remaining", v), 32'(obsRem),        32'(vecs[v].expRem));
      check($sformatf("vec%0d_inv_empty", v), 32'(bus.inv_empty), 32'(vecs[v].expEmpty));
    end

    // start 0: SELECT next cycle, done the cycle after, no eject.
    bus.change_cents = 14'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero_k1_busy", 32'(bus.busy), 32'd1);
    check("zero_k1_done", 32'(bus.done), 32'd0);
    tick();
    check("zero_k2_done",  32'(bus.done),  32'd1);
    check("zero_k2_eject", 32'(bus.eject), 32'd0);
    tick();
    check("zero_k3_done", 32'(bus.done), 32'd0);

    // Eject latency: eject valid two cycles after the start edge.
    loadInv({8'd1, 8'd0, 8'd0, 8'd0});
    bus.change_cents = 14'd100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("lat_k1_busy",  32'(bus.busy),  32'd1);
    check("lat_k1_eject", 32'(bus.eject), 32'd0);
    tick();
    check("lat_k2_eject", 32'(bus.eject), 32'b1000);
    bus.eject_ack = 1'b1;
    tick();
    bus.eject_ack = 1'b0;
    check("lat_ack_eject",     32'(bus.eject),     32'd0);
    check("lat_ack_remaining", 32'(bus.remaining), 32'd0);
    tick();
    check("lat_done",  32'(bus.done),  32'd1);
    check("lat_short", 32'(bus.short), 32'd0);
    tick();

    // Load and start together: load wins; eject_ack in IDLE is ignored.
    bus.inv_dollar = 8'd2; bus.inv_quarter = 8'd2; bus.inv_dime = 8'd2; bus.inv_nickel = 8'd2;
    for (int i = 0; i < 4; i++) modelInv[i] = 2;
    bus.change_cents = 14'd100;
    bus.inv_load = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.inv_load = 1'b0;
    bus.start = 1'b0;
    check("loadwins_busy",      32'(bus.busy),      32'd0);
    check("loadwins_inv_empty", 32'(bus.inv_empty), 32'd0);
    bus.eject_ack = 1'b1;
    tick();
    bus.eject_ack = 1'b0;
    check("idleack_busy", 32'(bus.busy), 32'd0);
    doPayout(14'd400, 0, 2);
    check("idleack_count",     32'(obsSeq.size()), 32'd8);
    check("idleack_short",     32'(obsShort),      32'd1);
    check("idleack_remaining", 32'(obsRem),        32'd120);

    // Acknowledge on the last permitted cycle: no fault.
    loadInv({8'd0, 8'd0, 8'd0, 8'd1});
    doPayout(14'd5, ACK_TIMEOUT - 1, ACK_TIMEOUT - 1);
    check("edge_ack_fault",     32'(bus.fault),     32'd0);
    check("edge_ack_short",     32'(obsShort),      32'd0);
    check("edge_ack_inv_empty", 32'(bus.inv_empty), 32'hF);

    // Randomized payouts against the reference model.
    for (int i = 0; i < 4; i++) rv[i] = 8'($urandom_range(6, 0));
    loadInv(rv);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(2, 0) == 0) begin
        for (int i = 0; i < 4; i++)
          rv[i] = ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom_range(6, 0));
        loadInv(rv);
      end
      cents = ($urandom_range(3, 0) == 0) ? int'($urandom_range(9995, 0))
                                          : int'($urandom_range(400, 0));
      modelPayout(cents);
      doPayout(14'(cents), 0, ACK_TIMEOUT - 1);
      check($sformatf("rnd%0d_c%0d_ncoins", it, cents), 32'(obsSeq.size()), 32'(expSeq.size()));
      n = (obsSeq.size() < expSeq.size()) ? obsSeq.size() : expSeq.size();
      for (int i = 0; i < n; i++)
        check($sformatf("rnd%0d_coin%0d", it, i), 32'(obsSeq[i]), 32'(expSeq[i]));
      check($sformatf("rnd%0d_short", it),     32'(obsShort),      32'(expShort));
      check($sformatf("rnd%0d_remaining", it), 32'(obsRem),        32'(expRem));
      check($sformatf("rnd%0d_inv_empty", it), 32'(bus.inv_empty), 32'(modelEmpty()));
    end

    // Hopper timeout: fault, eject dropped, everything ignored afterwards.
    loadInv({8'd0, 8'd0, 8'd0, 8'd2});
    bus.change_cents = 14'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.eject != 4'b0000) seen = 1;
      else tick();
    end
    check("to_eject_seen", 32'(seen), 32'd1);
    repeat (ACK_TIMEOUT - 1) tick();
    check("to_pre_fault", 32'(bus.fault), 32'd0);
    check("to_pre_eject", 32'(bus.eject), 32'b0001);
    tick();
    check("to_fault", 32'(bus.fault), 32'd1);
    check("to_eject", 32'(bus.eject), 32'd0);
    check("to_busy",  32'(bus.busy),  32'd0);
    bus.inv_dollar = 8'd5; bus.inv_quarter = 8'd5; bus.inv_dime = 8'd5; bus.inv_nickel = 8'd5;
    bus.change_cents = 14'd5;
    bus.start = 1'b1;
    bus.inv_load = 1'b1;
    bus.eject_ack = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    bus.inv_load = 1'b0;
    bus.eject_ack = 1'b0;
    tick();
    check("fault_sticky",    32'(bus.fault),     32'd1);
    check("fault_busy",      32'(bus.busy),      32'd0);
    check("fault_eject",     32'(bus.eject),     32'd0);
    check("fault_done",      32'(bus.done),      32'd0);
    check("fault_inv_empty", 32'(bus.inv_empty), 32'b1110);

    // Reset while ejecting: eject drops immediately, all state cleared.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    loadInv({8'd3, 8'd3, 8'd3, 8'd3});
    bus.change_cents = 14'd100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("mid_eject_active", 32'(bus.eject), 32'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    checkAllZero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
